card_list_reader: RTL
=====================

// Module: card_list_reader
// PURPOSE
// Walks a linked list of cards in the 1024x32 card RAM, from a given head address, and streams each card out over a valid/ready handshake.
// Read-side counterpart of the card store/remove writers; feeds the dealing and display logic.
// RAM word: [31]=valid, [21:20]=suit, [19:16]=value, [9:0]=next address. Other bits are zero.
// Address 10'd0 is reserved and means end of list.
// PARAMETERS
// MAX_CARDS   52   list-length limit; reaching it without hitting a terminator raises error (cycle guard)
// ADDR_W      10   RAM address width
// PORTS
// clock       in   1       system clock, rising edge
// resetn      in   1       asynchronous active-low reset
// start       in   1       1-cycle pulse; accepted only in IDLE, ignored otherwise
// head_addr   in   ADDR_W  address of the first card; sampled with start
// mem_addr    out  ADDR_W  RAM read address
// mem_q       in   32      RAM read data; valid 1 cycle after mem_addr is presented (synchronous RAM)
// card_valid  out  1       card output is valid
// card_ready  in   1       consumer accepts the card when card_valid && card_ready
// card_suit   out  2       suit of the presented card
// card_value  out  4       value of the presented card
// card_addr   out  ADDR_W  RAM address of the presented card
// card_index  out  6       0-based position of the card in the list
// busy        out  1       high from start acceptance until done
// done        out  1       1-cycle pulse when the walk ends (normally or by error)
// count       out  6       number of cards delivered; held until the next start
// error       out  1       sticky until the next start: cycle guard tripped or (optionally) bad word
// BEHAVIOUR
// - Reset (async, resetn=0): state=IDLE. mem_addr, count, card_index and card fields = 0; card_valid, busy, done, error = 0.
// - FSM states: IDLE -> FETCH -> WAIT -> PRESENT -> (FETCH | DONE) -> IDLE.
//   IDLE:    on start: if head_addr==0, go to DONE (count=0, no card emitted).
//            Otherwise latch head_addr into cur, clear count and error, set busy, go to FETCH.
//   FETCH:   mem_addr<=cur; go to WAIT.
//   WAIT:    capture mem_q into the card_* registers; card_addr<=cur; card_index<=count; next<=mem_q[9:0]; card_valid<=1; go to PRESENT.
//   PRESENT: hold all card_* outputs stable while card_valid && !card_ready.
//            On handshake: card_valid<=0 and count<=count+1.
//            If next==0: go to DONE.
//            Else if count+1==MAX_CARDS: set error, go to DONE.
//            Else cur<=next and go to FETCH.
//   DONE:    done=1 for exactly one cycle, busy<=0, go to IDLE.
// - Latency: start at edge N gives card_valid high after edge N+3. With card_ready tied high, throughput is 1 card per 3 cycles.
// - card_valid never drops without a handshake, except on reset.
// - start while busy is ignored; the walk is not restarted.
// - Reset mid-walk aborts immediately; no done pulse is produced.
// - count is 6 bits; MAX_CARDS must be <=63. No wrap-around is possible because the guard fires first.
// - A self-loop (next==cur) is caught only by the MAX_CARDS guard.
// CONFIGURATION
// CARD_READER_VALIDATE_EN defined: in WAIT, the word is rejected if mem_q[31]==0 or value is not in 1..13.
//   A rejected word sets error, is not emitted, and the FSM goes straight to DONE. count excludes the rejected card.
// CARD_READER_VALIDATE_EN undefined: mem_q is emitted unchecked. error is raised only by the MAX_CARDS guard.
// TESTING
// 1 3-card list 0x005->0x009->0x003->0, card_ready=1:
//   3 cards out in list order with card_index 0,1,2; done pulse; count=3; error=0.
// 2 head_addr=0 with start: no card_valid; done pulses 2 cycles after start; count=0.
// 3 Backpressure, card_ready low for 5 cycles on card 1:
//   outputs held stable, no skipped or duplicated card, final count correct.
// 4 Self-loop 0x004->0x004, MAX_CARDS=52: exactly 52 cards emitted, then error=1 and done.
// 5 Reset asserted while in PRESENT: all outputs 0 immediately. A following start with a 1-card list works normally.
// 6 VALIDATE_EN, second word has value=0: first card emitted, then error=1, done, count=1.
//   Without the macro the same list emits both cards and error=0.

Source files
------------

// File: rtl/card_list_reader.sv
// rtl/card_list_reader.sv - walks a linked card list in RAM and streams cards over valid/ready
// Optional feature macro: CARD_READER_VALIDATE_EN (reject invalid words during the walk)
module card_list_reader #(
    parameter int MAX_CARDS = 52,
    parameter int ADDR_W    = 10
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              start,
    input  logic [ADDR_W-1:0] head_addr,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_q,
    output logic              card_valid,
    input  logic              card_ready,
    output logic [1:0]        card_suit,
    output logic [3:0]        card_value,
    output logic [ADDR_W-1:0] card_addr,
    output logic [5:0]        card_index,
    output logic              busy,
    output logic              done,
    output logic [5:0]        count,
    output logic              error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_PRESENT,
        S_DONE
    } state_t;

    localparam logic [5:0] MAX_C = 6'(MAX_CARDS);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] cur;
    logic [ADDR_W-1:0] nxt_addr;
    logic              handshake;
    logic              word_bad;
    logic              last_card;
    logic              guard_hit;
    logic [5:0]        count_inc;
    logic              unused_bits;

    assign handshake = card_valid && card_ready;
    assign count_inc = count + 6'd1;
    assign last_card = (nxt_addr == '0);
    assign guard_hit = (count_inc == MAX_C);

`ifdef CARD_READER_VALIDATE_EN
    // A word is usable only if its valid flag is set and its value is a real rank (1..13)
    assign word_bad    = !mem_q[31] || (mem_q[19:16] == 4'd0) || (mem_q[19:16] > 4'd13);
    assign unused_bits = ^{mem_q[30:22], mem_q[15:10]};
`else
    assign word_bad    = 1'b0;
    assign unused_bits = ^{mem_q[31:22], mem_q[15:10]};
`endif

    // State register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic for the list walk
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (head_addr == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                state_nxt = word_bad ? S_DONE : S_PRESENT;
            end
            S_PRESENT: begin
                if (handshake) begin
                    if (last_card || guard_hit) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath: RAM address, captured card, counters and status flags.
    // The RAM address is issued as soon as the next card address is known, so the
    // synchronous RAM reads on the FETCH edge and its data is ready to capture in WAIT.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            mem_addr   <= '0;
            cur        <= '0;
            nxt_addr   <= '0;
            card_valid <= 1'b0;
            card_suit  <= 2'd0;
            card_value <= 4'd0;
            card_addr  <= '0;
            card_index <= 6'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            count      <= 6'd0;
            error      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        count    <= 6'd0;
                        error    <= 1'b0;
                        busy     <= 1'b1;
                        cur      <= head_addr;
                        mem_addr <= head_addr;
                    end
                end
                S_FETCH: begin
                    mem_addr <= cur;
                end
                S_WAIT: begin
                    if (word_bad) begin
                        error <= 1'b1;
                    end else begin
                        card_suit  <= mem_q[21:20];
                        card_value <= mem_q[19:16];
                        card_addr  <= cur;
                        card_index <= count;
                        nxt_addr   <= mem_q[ADDR_W-1:0];
                        card_valid <= 1'b1;
                    end
                end
                S_PRESENT: begin
                    if (handshake) begin
                        card_valid <= 1'b0;
                        count      <= count_inc;
                        if (!last_card) begin
                            if (guard_hit) begin
                                error <= 1'b1;
                            end else begin
                                cur      <= nxt_addr;
                                mem_addr <= nxt_addr;
                            end
                        end
                    end
                end
                S_DONE: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
